// File: rtl/oc15_share_ctrl.sv
// Round-robin time-sharing of one external combinational 15-input ones counter.
// Each grant takes IDLE -> DRIVE -> RESP; a golden popcount cross-checks every returned count.
module oc15_share_ctrl #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 15,
  parameter int unsigned CW    = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [WIDTH-1:0]      oc_in,
  input  logic [CW-1:0]         oc_count,
  output logic [NREQ-1:0]       ack,
  output logic                  valid,
  output logic [CW-1:0]         result,
  output logic [IDW-1:0]        result_id,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] oc_in_q;
  logic [IDW-1:0]   gid_q;
  logic [IDW-1:0]   ptr_q;
  logic [NREQ-1:0]  ack_q;
  logic             valid_q;
  logic [CW-1:0]    result_q;
  logic [IDW-1:0]   result_id_q;
  logic             busy_q;
  logic             err_q;

  logic             grant_found_c;
  logic [IDW-1:0]   grant_idx_c;
  logic [IDW-1:0]   cand_c;
  logic [WIDTH-1:0] grant_data_c;
  logic [NREQ-1:0]  ack_onehot_c;
  logic [CW-1:0]    golden_c;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      s = s + CW'(v[b]);
    end
    return s;
  endfunction

  // Search starts one past the last granted index, wrapping modulo NREQ.
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    cand_c        = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand_c = IDW'((32'(ptr_q) + i) % NREQ);
      if (!grant_found_c && req[cand_c]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = cand_c;
      end
    end
  end

  assign grant_data_c = data[32'(grant_idx_c)*WIDTH +: WIDTH];

  always_comb begin
    ack_onehot_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      ack_onehot_c[i] = (gid_q == IDW'(i));
    end
  end

  // oc_in_q doubles as the registered operand while in DRIVE.
  assign golden_c = popcount(oc_in_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      oc_in_q     <= '0;
      gid_q       <= '0;
      ptr_q       <= IDW'(NREQ - 1);
      ack_q       <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      result_id_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q   <= '0;
          valid_q <= 1'b0;
          if (grant_found_c) begin
            oc_in_q <= grant_data_c;
            gid_q   <= grant_idx_c;
            ptr_q   <= grant_idx_c;
            busy_q  <= 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          result_q    <= oc_count;
          result_id_q <= gid_q;
          if (oc_count != golden_c) begin
            err_q <= 1'b1;
          end
          oc_in_q <= '0;
          ack_q   <= ack_onehot_c;
          valid_q <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          ack_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          oc_in_q <= '0;
          ack_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign oc_in     = oc_in_q;
  assign ack       = ack_q;
  assign valid     = valid_q;
  assign result    = result_q;
  assign result_id = result_id_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_oc15_share_ctrl.sv
// Directed bench for oc15_share_ctrl with an external ones-counter model that can inject a fault.
module tb_oc15_share_ctrl;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 15;
  localparam int unsigned CW    = 4;
  localparam int unsigned IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [WIDTH-1:0]      oc_in;
  logic [CW-1:0]         oc_count;
  logic [NREQ-1:0]       ack;
  logic                  valid;
  logic [CW-1:0]         result;
  logic [IDW-1:0]        result_id;
  logic                  busy;
  logic                  err;
  logic                  fault_en;

  int n_checks;
  int n_fail;

  oc15_share_ctrl #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .CW   (CW),
    .IDW  (IDW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data     (data),
    .oc_in    (oc_in),
    .oc_count (oc_count),
    .ack      (ack),
    .valid    (valid),
    .result   (result),
    .result_id(result_id),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ones counter; fault_en flips the LSB of its answer.
  always_comb begin
    oc_count = CW'($countones(oc_in)) ^ {{(CW-1){1'b0}}, fault_en};
  end

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!valid && cyc < 12);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    int cyc;
    rst = 1'b1; req = '0; data = '0; fault_en = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({oc_in, ack, valid, result, result_id, busy, err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got oc_in=%0h ack=%b valid=%b result=%0d id=%0d busy=%b err=%b expected all 0",
                         oc_in, ack, valid, result, result_id, busy, err);
    end
    rst = 1'b0;
    idle(1);
    req = 4'b0001;
    data[0*WIDTH +: WIDTH] = 15'h7FFF;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1 || oc_in !== 15'h7FFF) begin
      n_fail++; $display("FAIL reset_pre_drive: got busy=%b oc_in=%0h expected busy=1 oc_in=7fff", busy, oc_in);
    end
    rst = 1'b1;
    #1;
    n_checks++; if ({oc_in, ack, valid, result, result_id, busy, err} !== '0) begin
      n_fail++; $display("FAIL reset_mid_drive: got oc_in=%0h ack=%b valid=%b busy=%b expected all 0", oc_in, ack, valid, busy);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++; if (ack !== '0 || valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_ack: got ack=%b valid=%b expected 0", ack, valid);
      end
    end
    rst = 1'b0;
    wait_valid(cyc);
    n_checks++; if (cyc !== 2) begin
      n_fail++; $display("FAIL reset_latency: got %0d cycles expected 2", cyc);
    end
    n_checks++; if (ack !== 4'b0001 || result !== 4'd15 || result_id !== 2'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_after_release: got ack=%b result=%0d id=%0d err=%b expected ack=0001 result=15 id=0 err=0",
                         ack, result, result_id, err);
    end
    req = '0;
    idle(2);
  endtask

  task automatic test_single;
    int cyc;
    data[2*WIDTH +: WIDTH] = 15'h0001;
    req = 4'b0100;
    wait_valid(cyc);
    n_checks++; if (cyc !== 2) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles expected 2", cyc);
    end
    n_checks++; if (ack !== 4'b0100 || result !== 4'd1 || result_id !== 2'd2) begin
      n_fail++; $display("FAIL single_result: got ack=%b result=%0d id=%0d expected ack=0100 result=1 id=2", ack, result, result_id);
    end
    req = '0;
    @(posedge clk); #1;
    n_checks++; if (ack !== '0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse_width: got ack=%b valid=%b expected ack=0000 valid=0", ack, valid);
    end
    n_checks++; if (result !== 4'd1 || result_id !== 2'd2) begin
      n_fail++; $display("FAIL single_result_hold: got result=%0d id=%0d expected 1 and 2", result, result_id);
    end
    idle(1);
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_fairness;
    int cyc;
    int id;
    logic [CW-1:0] exp_cnt [4];
    exp_cnt = '{4'd2, 4'd4, 4'd3, 4'd1};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    data = {15'h0001, 15'h7000, 15'h00F0, 15'h0003};
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      id = k % 4;
      wait_valid(cyc);
      n_checks++; if (cyc !== ((k == 0) ? 2 : 3)) begin
        n_fail++; $display("FAIL fair_spacing[%0d]: got %0d cycles expected %0d", k, cyc, (k == 0) ? 2 : 3);
      end
      n_checks++; if (result_id !== IDW'(id) || ack !== NREQ'(1 << id)) begin
        n_fail++; $display("FAIL fair_order[%0d]: got id=%0d ack=%b expected id=%0d", k, result_id, ack, id);
      end
      n_checks++; if ($countones(ack) !== 1) begin
        n_fail++; $display("FAIL fair_onehot[%0d]: got ack=%b expected exactly one bit", k, ack);
      end
      n_checks++; if (result !== exp_cnt[id]) begin
        n_fail++; $display("FAIL fair_result[%0d]: got %0d expected %0d", k, result, exp_cnt[id]);
      end
    end
    req = '0;
    idle(2);
  endtask

  task automatic test_operand_hold;
    data[1*WIDTH +: WIDTH] = 15'h5555;
    req = 4'b0010;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1 || oc_in !== 15'h5555) begin
      n_fail++; $display("FAIL hold_drive: got busy=%b oc_in=%0h expected busy=1 oc_in=5555", busy, oc_in);
    end
    data[1*WIDTH +: WIDTH] = 15'h0000;
    @(posedge clk); #1;
    n_checks++; if (valid !== 1'b1 || ack !== 4'b0010 || result !== 4'd8 || result_id !== 2'd1) begin
      n_fail++; $display("FAIL hold_result: got valid=%b ack=%b result=%0d id=%0d expected valid=1 ack=0010 result=8 id=1",
                         valid, ack, result, result_id);
    end
    req = '0;
    @(posedge clk); #1;
    n_checks++; if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_return_idle: got valid=%b busy=%b expected 0 0", valid, busy);
    end
    idle(1);
  endtask

  task automatic test_fault;
    int cyc;
    n_checks++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL fault_pre_err: got %b expected 0", err);
    end
    fault_en = 1'b1;
    data[3*WIDTH +: WIDTH] = 15'h0007;
    req = 4'b1000;
    wait_valid(cyc);
    n_checks++; if (result !== 4'd2 || err !== 1'b1) begin
      n_fail++; $display("FAIL fault_detect: got result=%0d err=%b expected result=2 err=1", result, err);
    end
    fault_en = 1'b0;
    req = '0;
    idle(2);
    data[0*WIDTH +: WIDTH] = 15'h00FF;
    req = 4'b0001;
    wait_valid(cyc);
    n_checks++; if (result !== 4'd8 || err !== 1'b1) begin
      n_fail++; $display("FAIL fault_sticky: got result=%0d err=%b expected result=8 err=1", result, err);
    end
    req = '0;
    idle(3);
    n_checks++; if (err !== 1'b1) begin
      n_fail++; $display("FAIL fault_sticky_idle: got %b expected 1", err);
    end
    rst = 1'b1;
    #1;
    n_checks++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL fault_clear_by_rst: got %b expected 0", err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_back_to_back_sweep;
    int cyc;
    logic [WIDTH-1:0] v;
    v = '0;
    data[3*WIDTH +: WIDTH] = v;
    req = 4'b1000;
    for (int k = 0; k < 34; k++) begin
      wait_valid(cyc);
      n_checks++; if (cyc !== ((k == 0) ? 2 : 3)) begin
        n_fail++; $display("FAIL sweep_spacing[%0d]: got %0d cycles expected %0d", k, cyc, (k == 0) ? 2 : 3);
      end
      n_checks++; if (result !== CW'($countones(v)) || result_id !== 2'd3 || ack !== 4'b1000) begin
        n_fail++; $display("FAIL sweep_result[%0h]: got result=%0d id=%0d ack=%b expected result=%0d id=3 ack=1000",
                           v, result, result_id, ack, $countones(v));
      end
      v = (k == 32) ? 15'h7FFF : WIDTH'((k + 1) * 1021);
      data[3*WIDTH +: WIDTH] = v;
    end
    req = '0;
    idle(2);
    n_checks++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL sweep_err: got %b expected 0", err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_operand_hold();
    test_fault();
    test_back_to_back_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
